valet_dispatcher: RTL

//  Initiator side of the parking-lot stack interface. Accepts park/retrieve requests on a valid/ready port,

---
 rtl/valet_pkg.sv | 27 ++
 rtl/valet_dispatcher_if.sv | 52 +++++
 rtl/valet_req_fifo.sv | 67 ++++++
 rtl/valet_dispatcher.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/valet_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// valet_pkg : shared types, constants and helpers for the valet dispatcher
// Rev 1.0
// ----------------------------------------------------------------------------
package valet_pkg;

  localparam int STAT_WIDTH = 16;

  typedef enum logic {
    OP_PARK     = 1'b0,
    OP_RETRIEVE = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RETURN  = 2'd3
  } disp_state_e;

  function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
    return (v == {STAT_WIDTH{1'b1}}) ? v : v + STAT_WIDTH'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/valet_dispatcher_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// valet_dispatcher_if : request, return, lot and status signals of the dispatcher
// Rev 1.0
// ----------------------------------------------------------------------------
interface valet_dispatcher_if
  import valet_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) ();

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_op;
  logic [DATA_WIDTH-1:0] req_tag;

  logic                  ret_valid;
  logic                  ret_ready;
  logic [DATA_WIDTH-1:0] ret_tag;

  logic                  lot_write_enable;
  logic                  lot_read_enable;
  logic [DATA_WIDTH-1:0] lot_data_in;
  logic [DATA_WIDTH-1:0] lot_data_out;
  logic                  lot_full;
  logic                  lot_empty;
  logic                  lot_cooldown_active;

  logic                  reject_pulse;
  logic                  stall_error;
  logic [STAT_WIDTH-1:0] stat_parks;
  logic [STAT_WIDTH-1:0] stat_retrieves;
  logic [STAT_WIDTH-1:0] stat_rejects;

  modport master (
    input  req_valid, req_op, req_tag, ret_ready,
    input  lot_data_out, lot_full, lot_empty, lot_cooldown_active,
    output req_ready, ret_valid, ret_tag,
    output lot_write_enable, lot_read_enable, lot_data_in,
    output reject_pulse, stall_error, stat_parks, stat_retrieves, stat_rejects
  );

  modport slave (
    output req_valid, req_op, req_tag, ret_ready,
    output lot_data_out, lot_full, lot_empty, lot_cooldown_active,
    input  req_ready, ret_valid, ret_tag,
    input  lot_write_enable, lot_read_enable, lot_data_in,
    input  reject_pulse, stall_error, stat_parks, stat_retrieves, stat_rejects
  );

endinterface
`default_nettype wire

// File: rtl/valet_req_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// valet_req_fifo : synchronous request FIFO; reset clears pointers only
// Rev 1.0
// ----------------------------------------------------------------------------
module valet_req_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             w_push;
  logic             w_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;

  // Power-of-two depth lets the pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (w_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule
`default_nettype wire

// File: rtl/valet_dispatcher.sv
`default_nettype none
// ----------------------------------------------------------------------------
// valet_dispatcher : buffers park/retrieve requests and strobes them into the LIFO lot
// Macro VALET_STATS_EN builds saturating park/retrieve/reject counters. Rev 1.0
// ----------------------------------------------------------------------------
module valet_dispatcher
  import valet_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int REQ_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                clk,
  input  logic                reset,
  valet_dispatcher_if.master  dif
);

  localparam int                WAIT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT_CYCLES);

  disp_state_e           state_q, state_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic                  ret_valid_q, ret_valid_d;
  logic [DATA_WIDTH-1:0] ret_tag_q, ret_tag_d;
  logic                  stall_q, stall_d;

  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic                  w_push;
  logic                  w_pop;
  logic [DATA_WIDTH:0]   w_head;
  op_e                   w_head_op;
  logic [DATA_WIDTH-1:0] w_head_tag;
  logic                  w_we;
  logic                  w_re;
  logic                  w_reject;

  // No bypass: a dequeue in the same cycle does not open a full FIFO.
  assign dif.req_ready = !w_fifo_full && !reset;
  assign w_push        = dif.req_valid && dif.req_ready;
  assign w_head_op     = op_e'(w_head[DATA_WIDTH]);
  assign w_head_tag    = w_head[DATA_WIDTH-1:0];

  valet_req_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (REQ_DEPTH)
  ) u_req_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .data_i  ({dif.req_op, dif.req_tag}),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty),
    .head_o  (w_head)
  );

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    ret_valid_d = ret_valid_q;
    ret_tag_d   = ret_tag_q;
    stall_d     = stall_q;
    w_we        = 1'b0;
    w_re        = 1'b0;
    w_reject    = 1'b0;
    w_pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!w_fifo_empty) state_d = ISSUE;
      end
      ISSUE: begin
        // Lot capacity outranks the timeout, which outranks waiting out cooldown.
        if ((w_head_op == OP_PARK && dif.lot_full) ||
            (w_head_op == OP_RETRIEVE && dif.lot_empty)) begin
          w_reject = 1'b1;
          w_pop    = 1'b1;
          state_d  = IDLE;
        end else if (wait_q == WAIT_MAX) begin
          w_reject = 1'b1;
          w_pop    = 1'b1;
          stall_d  = 1'b1;
          state_d  = IDLE;
        end else if (dif.lot_cooldown_active) begin
          wait_d = wait_q + WAIT_W'(1);
        end else if (w_head_op == OP_PARK) begin
          w_we    = 1'b1;
          w_pop   = 1'b1;
          state_d = IDLE;
        end else begin
          w_re    = 1'b1;
          w_pop   = 1'b1;
          state_d = CAPTURE;
        end
        if (state_d != ISSUE) wait_d = '0;
      end
      CAPTURE: begin
        ret_tag_d   = dif.lot_data_out;
        ret_valid_d = 1'b1;
        state_d     = RETURN;
      end
      RETURN: begin
        if (dif.ret_ready) begin
          ret_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      wait_q      <= '0;
      ret_valid_q <= 1'b0;
      ret_tag_q   <= '0;
      stall_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      ret_valid_q <= ret_valid_d;
      ret_tag_q   <= ret_tag_d;
      stall_q     <= stall_d;
    end
  end

  assign dif.lot_write_enable = w_we;
  assign dif.lot_read_enable  = w_re;
  assign dif.lot_data_in      = w_we ? w_head_tag : '0;
  assign dif.reject_pulse     = w_reject;
  assign dif.stall_error      = stall_q;
  assign dif.ret_valid        = ret_valid_q;
  assign dif.ret_tag          = ret_tag_q;

`ifdef VALET_STATS_EN
  logic [STAT_WIDTH-1:0] parks_q, retrieves_q, rejects_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parks_q     <= '0;
      retrieves_q <= '0;
      rejects_q   <= '0;
    end else begin
      if (w_we)     parks_q     <= sat_inc(parks_q);
      if (w_re)     retrieves_q <= sat_inc(retrieves_q);
      if (w_reject) rejects_q   <= sat_inc(rejects_q);
    end
  end

  assign dif.stat_parks     = parks_q;
  assign dif.stat_retrieves = retrieves_q;
  assign dif.stat_rejects   = rejects_q;
`else
  assign dif.stat_parks     = '0;
  assign dif.stat_retrieves = '0;
  assign dif.stat_rejects   = '0;
`endif

endmodule
`default_nettype wire
